id_ex_etapa: RTL
================

Name: id_ex_etapa

Overview:
- Decode-side stage directly downstream of the register file (bancoDeRegistros) in the 5-stage MIPS pipeline.
- Drives the register file read addresses from the IF/ID instruction and decodes control fields.
- Bypasses same-cycle write-back data that the register file has not yet committed; detects load-use hazards.
- Registers everything into the ID/EX pipeline register consumed by the execute stage.

Parameters:
- DATA_WIDTH, 32, datapath width.
- ADDRESS_WIDTH, 5, register index width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- instruction  in  32  IF/ID instruction.
- pc_plus4  in  DATA_WIDTH  IF/ID PC+4.
- addressA  out  ADDRESS_WIDTH  to register file; instruction[25:21] (rs), combinational.
- addressB  out  ADDRESS_WIDTH  to register file; instruction[20:16] (rt), combinational.
- regA, regB  in  DATA_WIDTH  register file read data.
- wb_we  in  1  write-back enable (same signal as register file we).
- wb_address  in  ADDRESS_WIDTH  write-back register index.
- wb_data  in  DATA_WIDTH  write-back data.
- flush  in  1  kill the ID instruction (taken branch).
- stall  out  1  load-use stall to PC and IF/ID; combinational.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_regA, ex_regB  out  DATA_WIDTH  operand values.
- ex_imm  out  DATA_WIDTH  extended immediate.
- ex_rs, ex_rt, ex_rd  out  ADDRESS_WIDTH  register indices.
- ex_pc_plus4  out  DATA_WIDTH  PC+4 for branch target.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst  out  1 each  control.
- ex_alu_op  out  3  000 add, 001 sub, 010 R-type(funct), 011 and, 100 or, 101 lui.

Behaviour:
- Reset (reset=0, async): all ex_* outputs 0, including ex_valid.
- Latency: 1 cycle; ID/EX register loads on every rising clk edge. No enable; stall is realised as a bubble.
- Decode by opcode [31:26]:
  - 0x00 R-type: reg_write=1, reg_dst=1, alu_op=010.
  - 0x23 lw: mem_read=1, reg_write=1, alu_src=1, alu_op=000.
  - 0x2B sw: mem_write=1, alu_src=1, alu_op=000.
  - 0x04 beq: branch=1, alu_op=001.
  - 0x08 addi: reg_write=1, alu_src=1, alu_op=000.
  - 0x0C andi: alu_op=011; 0x0D ori: alu_op=100; 0x0F lui: alu_op=101. All three: reg_write=1, alu_src=1.
  - Any other opcode: all controls 0, ex_valid=1.
- Immediate: andi/ori zero-extend [15:0]; all other opcodes sign-extend [15:0].
- Destination index (rd if reg_dst else rt) equal to 0 forces ex_reg_write=0, so NOP 0x00000000 writes nothing.
- WB bypass:
  - ex_regA <= wb_data if wb_we && wb_address!=0 && wb_address==rs, else regA.
  - ex_regB uses the same rule with rt.
  - Both bypasses can fire simultaneously.
- Load-use hazard: stall = !flush && ex_valid && ex_mem_read && ex_rt!=0 && (ex_rt==rs || (ex_rt==rt && opcode in {R-type, sw, beq})).
- On stall: next ID/EX is a bubble (ex_valid=0, all controls 0; data fields don't-care but held at 0). The upstream stage holds the instruction, so it is decoded again the following cycle. Stall lasts exactly 1 cycle, because the bubble has ex_mem_read=0.
- flush has priority over stall: next ID/EX is a bubble and stall=0.
- reset asserted mid-stall: outputs clear immediately; stall drops because ex_valid=0.

Decomposition:
- Shared package mips_defs: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI), the ALU_OP_* encodings, DATA_WIDTH/ADDRESS_WIDTH defaults.
- One sub-module, unidad_control: purely combinational opcode→control decoder, reusable by a later hazard unit.
- Bypass mux, hazard detection and the pipeline register stay in id_ex_etapa.

Test Plan:
- Reset: reset=0 mid-run with ex_valid=1 → all ex_* = 0 immediately, stall=0.
- Immediates: addi $2,$0,-1 (0x2002FFFF) → next cycle ex_imm=0xFFFFFFFF, ex_reg_write=1, ex_alu_src=1, ex_rt=2. ori 0x3402FFFF → ex_imm=0x0000FFFF.
- WB bypass: regA=0x1111, wb_we=1, wb_address=2, wb_data=0x8 with rs=2, rt=2 → ex_regA=ex_regB=0x8. Same with wb_address=0, wb_data=0x5 → ex_regA=0x1111 (no bypass).
- Load-use: lw $3,0($0) followed by add $4,$3,$1 → stall=1 for one cycle, bubble (ex_valid=0) enters EX, then add enters with ex_rs=3. With sw $3 instead of add → also stalls. addi $5,$0,$3-style (rt is destination only, rt=3) → no stall.
- Flush vs stall: the load-use case with flush=1 → stall=0, next ex_valid=0.
- NOP/illegal: 0x00000000 → ex_valid=1, ex_reg_write=0. Opcode 0x3F → ex_valid=1, all controls 0.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALU op encodings, widths.
// Imported by the decode-side pipeline stages.
package mips_defs;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_SUB   = 3'b001;
  localparam logic [2:0] ALU_OP_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OP_AND   = 3'b011;
  localparam logic [2:0] ALU_OP_OR    = 3'b100;
  localparam logic [2:0] ALU_OP_LUI   = 3'b101;

  // Opcodes whose rt field is a source operand, not a destination.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/id_ex_etapa_unidad_control.sv
// Main control decoder: opcode to datapath control signals.
// Purely combinational so a hazard unit can reuse it.
module unidad_control
  import mips_defs::*;
(
  input  logic [5:0] opcode_i,
  output logic       reg_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       branch_o,
  output logic       alu_src_o,
  output logic       reg_dst_o,
  output logic [2:0] alu_op_o,
  output logic       zero_ext_o
);

  always_comb begin
    reg_write_o = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    branch_o    = 1'b0;
    alu_src_o   = 1'b0;
    reg_dst_o   = 1'b0;
    alu_op_o    = ALU_OP_ADD;
    zero_ext_o  = 1'b0;
    unique case (1'b1)
      opcode_i == OP_RTYPE: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        alu_op_o    = ALU_OP_FUNCT;
      end
      opcode_i == OP_LW: begin
        mem_read_o  = 1'b1;
        reg_write_o = 1'b1;
        alu_src_o   = 1'b1;
      end
      opcode_i == OP_SW: begin
        mem_write_o = 1'b1;
        alu_src_o   = 1'b1;
      end
      opcode_i == OP_BEQ: begin
        branch_o = 1'b1;
        alu_op_o = ALU_OP_SUB;
      end
      opcode_i == OP_ADDI: begin
        reg_write_o = 1'b1;
        alu_src_o   = 1'b1;
      end
      opcode_i == OP_ANDI: begin
        reg_write_o = 1'b1;
        alu_src_o   = 1'b1;
        alu_op_o    = ALU_OP_AND;
        zero_ext_o  = 1'b1;
      end
      opcode_i == OP_ORI: begin
        reg_write_o = 1'b1;
        alu_src_o   = 1'b1;
        alu_op_o    = ALU_OP_OR;
        zero_ext_o  = 1'b1;
      end
      opcode_i == OP_LUI: begin
        reg_write_o = 1'b1;
        alu_src_o   = 1'b1;
        alu_op_o    = ALU_OP_LUI;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_etapa.sv
// ID stage: register-file addressing, decode, WB bypass,
// load-use bubble insertion and the ID/EX pipeline register.
module id_ex_etapa #(
  parameter int DATA_WIDTH    = mips_defs::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = mips_defs::ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              instruction,
  input  logic [DATA_WIDTH-1:0]    pc_plus4,
  output logic [ADDRESS_WIDTH-1:0] addressA,
  output logic [ADDRESS_WIDTH-1:0] addressB,
  input  logic [DATA_WIDTH-1:0]    regA,
  input  logic [DATA_WIDTH-1:0]    regB,
  input  logic                     wb_we,
  input  logic [ADDRESS_WIDTH-1:0] wb_address,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     flush,
  output logic                     stall,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    ex_regA,
  output logic [DATA_WIDTH-1:0]    ex_regB,
  output logic [DATA_WIDTH-1:0]    ex_imm,
  output logic [ADDRESS_WIDTH-1:0] ex_rs,
  output logic [ADDRESS_WIDTH-1:0] ex_rt,
  output logic [ADDRESS_WIDTH-1:0] ex_rd,
  output logic [DATA_WIDTH-1:0]    ex_pc_plus4,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_branch,
  output logic                     ex_alu_src,
  output logic                     ex_reg_dst,
  output logic [2:0]               ex_alu_op
);

  import mips_defs::*;

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic [5:0]    opcode;
  logic [AW-1:0] rs, rt, rd, dest;
  logic [15:0]   imm16;

  assign opcode = instruction[31:26];
  assign rs     = instruction[21 +: AW];
  assign rt     = instruction[16 +: AW];
  assign rd     = instruction[11 +: AW];
  assign imm16  = instruction[15:0];

  assign addressA = rs;
  assign addressB = rt;

  logic       c_reg_write, c_mem_read, c_mem_write;
  logic       c_branch, c_alu_src, c_reg_dst, c_zero_ext;
  logic [2:0] c_alu_op;

  unidad_control u_control (
    .opcode_i    (opcode),
    .reg_write_o (c_reg_write),
    .mem_read_o  (c_mem_read),
    .mem_write_o (c_mem_write),
    .branch_o    (c_branch),
    .alu_src_o   (c_alu_src),
    .reg_dst_o   (c_reg_dst),
    .alu_op_o    (c_alu_op),
    .zero_ext_o  (c_zero_ext)
  );

  logic [DW-1:0] imm_ext, opA, opB;
  logic          byp_a, byp_b, rw_eff;

  assign imm_ext = c_zero_ext ? {{(DW-16){1'b0}}, imm16}
                              : {{(DW-16){imm16[15]}}, imm16};

  // The register file commits at the edge, so same-cycle WB is forwarded.
  assign byp_a = wb_we && (wb_address != '0) && (wb_address == rs);
  assign byp_b = wb_we && (wb_address != '0) && (wb_address == rt);
  assign opA   = byp_a ? wb_data : regA;
  assign opB   = byp_b ? wb_data : regB;

  assign dest   = c_reg_dst ? rd : rt;
  assign rw_eff = c_reg_write && (dest != '0);

  logic          ex_valid_q, ex_valid_d;
  logic [DW-1:0] ex_regA_q, ex_regA_d;
  logic [DW-1:0] ex_regB_q, ex_regB_d;
  logic [DW-1:0] ex_imm_q, ex_imm_d;
  logic [AW-1:0] ex_rs_q, ex_rs_d;
  logic [AW-1:0] ex_rt_q, ex_rt_d;
  logic [AW-1:0] ex_rd_q, ex_rd_d;
  logic [DW-1:0] ex_pc_q, ex_pc_d;
  logic          ex_rw_q, ex_rw_d;
  logic          ex_mr_q, ex_mr_d;
  logic          ex_mw_q, ex_mw_d;
  logic          ex_br_q, ex_br_d;
  logic          ex_as_q, ex_as_d;
  logic          ex_rdst_q, ex_rdst_d;
  logic [2:0]    ex_op_q, ex_op_d;
  logic          bubble;

  assign stall = !flush && ex_valid_q && ex_mr_q && (ex_rt_q != '0) &&
                 ((ex_rt_q == rs) || ((ex_rt_q == rt) && reads_rt(opcode)));

  assign bubble = flush || stall;

  always_comb begin
    ex_valid_d = 1'b0;
    ex_regA_d  = '0;
    ex_regB_d  = '0;
    ex_imm_d   = '0;
    ex_rs_d    = '0;
    ex_rt_d    = '0;
    ex_rd_d    = '0;
    ex_pc_d    = '0;
    ex_rw_d    = 1'b0;
    ex_mr_d    = 1'b0;
    ex_mw_d    = 1'b0;
    ex_br_d    = 1'b0;
    ex_as_d    = 1'b0;
    ex_rdst_d  = 1'b0;
    ex_op_d    = '0;
    if (!bubble) begin
      ex_valid_d = 1'b1;
      ex_regA_d  = opA;
      ex_regB_d  = opB;
      ex_imm_d   = imm_ext;
      ex_rs_d    = rs;
      ex_rt_d    = rt;
      ex_rd_d    = rd;
      ex_pc_d    = pc_plus4;
      ex_rw_d    = rw_eff;
      ex_mr_d    = c_mem_read;
      ex_mw_d    = c_mem_write;
      ex_br_d    = c_branch;
      ex_as_d    = c_alu_src;
      ex_rdst_d  = c_reg_dst;
      ex_op_d    = c_alu_op;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q <= 1'b0;
      ex_regA_q  <= '0;
      ex_regB_q  <= '0;
      ex_imm_q   <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
      ex_pc_q    <= '0;
      ex_rw_q    <= 1'b0;
      ex_mr_q    <= 1'b0;
      ex_mw_q    <= 1'b0;
      ex_br_q    <= 1'b0;
      ex_as_q    <= 1'b0;
      ex_rdst_q  <= 1'b0;
      ex_op_q    <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_regA_q  <= ex_regA_d;
      ex_regB_q  <= ex_regB_d;
      ex_imm_q   <= ex_imm_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_rd_q    <= ex_rd_d;
      ex_pc_q    <= ex_pc_d;
      ex_rw_q    <= ex_rw_d;
      ex_mr_q    <= ex_mr_d;
      ex_mw_q    <= ex_mw_d;
      ex_br_q    <= ex_br_d;
      ex_as_q    <= ex_as_d;
      ex_rdst_q  <= ex_rdst_d;
      ex_op_q    <= ex_op_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_regA      = ex_regA_q;
  assign ex_regB      = ex_regB_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rs        = ex_rs_q;
  assign ex_rt        = ex_rt_q;
  assign ex_rd        = ex_rd_q;
  assign ex_pc_plus4  = ex_pc_q;
  assign ex_reg_write = ex_rw_q;
  assign ex_mem_read  = ex_mr_q;
  assign ex_mem_write = ex_mw_q;
  assign ex_branch    = ex_br_q;
  assign ex_alu_src   = ex_as_q;
  assign ex_reg_dst   = ex_rdst_q;
  assign ex_alu_op    = ex_op_q;

endmodule
